// File: rtl/uart_instruction_rx.sv
// 8N1 UART receiver that packs four bytes, least-significant byte first, into one 32-bit instruction word.
// A framing error or an inter-byte timeout discards the partial word, so later words stay aligned.
module uart_instruction_rx #(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rx,
   output logic [31:0] o_instruction,
   output logic        o_data_received,
   output logic        o_frame_error,
   output logic        o_timeout,
   output logic [1:0]  o_byte_count,
   output logic        o_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TIMEOUT_CLKS = CLKS_PER_BIT * TIMEOUT_BITS;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);
   localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic [1:0]    sync_q;
   logic          rx_s;
   state_t        state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [23:0]   word_q, word_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic          data_rcv_q, data_rcv_d;
   logic          frame_err_q, frame_err_d;
   logic          timeout_q, timeout_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q      <= 2'b11;
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         word_q      <= '0;
         byte_cnt_q  <= '0;
         instr_q     <= '0;
         data_rcv_q  <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
         to_cnt_q    <= '0;
      end else begin
         sync_q      <= {sync_q[0], i_rx};
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         word_q      <= word_d;
         byte_cnt_q  <= byte_cnt_d;
         instr_q     <= instr_d;
         data_rcv_q  <= data_rcv_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      word_d      = word_q;
      byte_cnt_d  = byte_cnt_q;
      instr_d     = instr_q;
      data_rcv_d  = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
      to_cnt_d    = '0;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
            end
         end
         S_START: begin
            // Re-check the line mid start bit; a high level means it was only a glitch.
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
                  case (byte_cnt_q)
                     2'd0:    word_d[7:0]   = shift_q;
                     2'd1:    word_d[15:8]  = shift_q;
                     2'd2:    word_d[23:16] = shift_q;
                     default: begin
                        instr_d    = {shift_q, word_q};
                        data_rcv_d = 1'b1;
                     end
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end else begin
                  frame_err_d = 1'b1;
                  byte_cnt_d  = '0;
                  state_d     = S_WAIT_HIGH;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout only runs between bytes of a partial word; a coincident start bit begins a fresh word.
      if (state_q == S_IDLE && byte_cnt_q != 2'd0) begin
         if (to_cnt_q == TO_LAST) begin
            timeout_d  = 1'b1;
            byte_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   assign o_instruction   = instr_q;
   assign o_data_received = data_rcv_q;
   assign o_frame_error   = frame_err_q;
   assign o_timeout       = timeout_q;
   assign o_byte_count    = byte_cnt_q;
   assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_instruction_rx.sv
// Bench for uart_instruction_rx: table of words plus hand-written glitch, framing, timeout and reset sequences.
// Expected words and strobe cycles go into a scoreboard queue and are popped when o_data_received fires.
module tb_uart_instruction_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_rx = 1'b1;
   logic [31:0] o_instruction;
   logic        o_data_received;
   logic        o_frame_error;
   logic        o_timeout;
   logic [1:0]  o_byte_count;
   logic        o_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_dr  = 0;
   int n_fe  = 0;
   int n_to  = 0;

   typedef struct {
      logic [31:0] word;
      int          exp_cyc;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [31:0] word;
      int          idle_bits;
   } vec_t;
   vec_t vecs[4];

   uart_instruction_rx #(
      .CLK_FREQ    (1000000),
      .BAUD        (100000),
      .TIMEOUT_BITS(8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_rx           (i_rx),
      .o_instruction  (o_instruction),
      .o_data_received(o_data_received),
      .o_frame_error  (o_frame_error),
      .o_timeout      (o_timeout),
      .o_byte_count   (o_byte_count),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard side: every strobe must match the oldest expected word at the expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (o_data_received) begin
            n_dr++;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got instruction 0x%0h with no word pending (cycle %0d)", o_instruction, cyc);
            end else begin
               e = sb_q.pop_front();
               check("word", o_instruction, e.word);
               check("strobe_cycle", cyc, e.exp_cyc);
            end
         end
         if (o_frame_error) n_fe++;
         if (o_timeout) n_to++;
         if ((32'(o_data_received) + 32'(o_frame_error) + 32'(o_timeout)) > 1) begin
            check("strobes_exclusive", {o_data_received, o_frame_error, o_timeout}, 3'b000);
         end
      end
   end

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      i_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a posedge; stop_low_clks > 0 holds the stop bit low that long.
   task automatic send_frame(input logic [7:0] b, input int stop_low_clks);
      hold(1'b0, 10);
      for (int i = 0; i < 8; i++) hold(b[i], 10);
      if (stop_low_clks > 0) hold(1'b0, stop_low_clks);
      hold(1'b1, 10);
   endtask

   // Strobe expected 98 edges after the start bit: 2 sync flops, detect, half bit, 8 data bits, mid stop bit.
   task automatic send_word(input logic [31:0] w);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            e.word    = w;
            e.exp_cyc = cyc + 98;
            sb_q.push_back(e);
         end
         send_frame(w[8*i +: 8], 0);
         check("byte_count_step", 32'(o_byte_count), 32'((i + 1) % 4));
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_instr"}, o_instruction, 32'h0);
      check({name, "_flags"}, {o_data_received, o_frame_error, o_timeout, o_byte_count, o_busy}, 6'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{word: 32'h00210233, idle_bits: 0};
      vecs[1] = '{word: 32'h00208213, idle_bits: 50};
      vecs[2] = '{word: 32'hDEADBEEF, idle_bits: 45};
      vecs[3] = '{word: 32'h80000001, idle_bits: 40};

      // Reset and quiet idle line
      rst  = 1'b0;
      i_rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         check_all_zero("post_reset_idle");
      end

      // Table-driven words
      foreach (vecs[v]) begin
         idle(vecs[v].idle_bits * 10);
         send_word(vecs[v].word);
      end
      idle(20);
      check("table_strobes", n_dr, 4);
      check("table_no_frame_err", n_fe, 0);
      check("table_no_timeout", n_to, 0);
      check("table_last_word_held", o_instruction, 32'h80000001);

      // Start-bit glitch shorter than half a bit
      hold(1'b0, 3);
      idle(30);
      check("glitch_byte_count", 32'(o_byte_count), 32'd0);
      check("glitch_not_busy", 32'(o_busy), 32'd0);
      check("glitch_no_frame_err", n_fe, 0);

      // Framing error mid word discards the partial word
      send_frame(8'h11, 0);
      check("pre_fe_byte_count", 32'(o_byte_count), 32'd1);
      send_frame(8'hA5, 30);
      idle(5);
      check("frame_err_pulses", n_fe, 1);
      check("fe_byte_count", 32'(o_byte_count), 32'd0);
      check("fe_no_strobe", n_dr, 4);
      send_word(32'h12345678);
      idle(20);

      // Inter-byte timeout
      send_frame(8'h44, 0);
      send_frame(8'h55, 0);
      check("pre_to_byte_count", 32'(o_byte_count), 32'd2);
      idle(100);
      check("timeout_pulses", n_to, 1);
      check("to_byte_count", 32'(o_byte_count), 32'd0);
      send_word(32'h00100093);
      idle(20);
      check("after_to_word", o_instruction, 32'h00100093);

      // Reset during the third byte's data bits
      send_frame(8'h01, 0);
      send_frame(8'h02, 0);
      hold(1'b0, 10);
      hold(1'b1, 10);
      hold(1'b0, 10);
      hold(1'b1, 10);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check_all_zero("mid_word_reset");
      idle(100);
      check_all_zero("after_reset_idle");
      check("reset_no_timeout", n_to, 1);
      send_word(32'hCAFEF00D);
      idle(20);

      check("total_strobes", n_dr, 7);
      check("total_frame_err", n_fe, 1);
      check("total_timeout", n_to, 1);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
